seven_seg_scan_mux: RTL and testbench
=====================================

// Module: seven_seg_scan_mux
// PURPOSE
//  Time-multiplexed N-digit hex display driver for the Basys3 common-anode display.
//  Digit values are double-buffered: a load strobe captures them, and they are applied only at a frame boundary, so digits never tear.
//  Each slot drives one anode and decodes that digit to active-low segments (seg[6]=a .. seg[0]=g).
//  Each slot starts with anti-ghost guard cycles, and optional leading-zero suppression applies.
// PARAMETERS
//  NUM_DIGITS    4       digits scanned, 1..8
//  REFRESH_DIV   100000  clk cycles per digit slot (>= GUARD_CYCLES+1)
//  GUARD_CYCLES  8       cycles at slot start with all anodes off
//  LZ_SUPPRESS   0       1: blank leading zero digits (digit 0 never blanked)
// PORTS
//  clk         in   1             system clock
//  rst         in   1             async active-high reset
//  load        in   1             1-cycle strobe: capture digits_in/blank_in/dp_in
//  digits_in   in   4*NUM_DIGITS  hex nibbles, digit i = [4i+3:4i], digit 0 rightmost
//  blank_in    in   NUM_DIGITS    1 = force digit i dark
//  dp_in       in   NUM_DIGITS    1 = light decimal point of digit i
//  seg         out  7             active-low segments a..g (bit6=a)
//  dp          out  1             active-low decimal point
//  an          out  NUM_DIGITS    active-low anodes, one-hot-low when lit
//  frame_tick  out  1             1-cycle pulse when scan wraps to digit 0
//  pending     out  1             1 = captured data not yet applied
// BEHAVIOUR
//  - Reset (async, rst=1): prescaler=0, index=0, active and shadow buffers=0, pending=0,
//    an=all 1, seg=7'b1111111, dp=1, frame_tick=0.
//  - Prescaler counts 0..REFRESH_DIV-1 and wraps.
//  - At REFRESH_DIV-1, index advances: NUM_DIGITS-1 -> 0 wraps.
//  - frame_tick=1 on the cycle after the wrap; it is registered together with index=0.
//  - Shadow load:
//    - load=1 captures inputs into shadow and sets pending=1.
//    - At a wrap, if pending=1, shadow copies to active and pending clears.
//    - load on the wrap cycle itself copies inputs straight to active, with pending=0.
//    - A second load before the wrap overwrites shadow; last load wins.
//  - Per-digit decode (combinational from active[index]); hex to seg:
//    - 0:0000001  1:1001111  2:0010010  3:0000110  4:1001100  5:0100100  6:0100000  7:0001111
//    - 8:0000000  9:0000100  A:0001000  b:1100000  C:0110001  d:1000010  E:0110000  F:0111000
//  - Dark digit: seg=1111111 and dp=1. A digit is dark if any of the following holds:
//    - blank_in[i] is set;
//    - LZ_SUPPRESS=1, i>0, and digits i..NUM_DIGITS-1 are all zero and none is blank-forced;
//    - this is a leading position with a higher digit blanked, which counts as zero.
//  - Lit digit: dp output = ~dp_in[i].
//  - Guard: while prescaler < GUARD_CYCLES, an=all 1 and seg/dp=all 1.
//  - Otherwise an[index]=0 and all other anodes=1, including when the digit is dark.
//  - Outputs are registered: 1-cycle latency from prescaler/index state to an/seg/dp.
//  - NUM_DIGITS=1: index is always 0 and frame_tick pulses every slot.
// TESTING (NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1 unless noted)
//  1. Hold rst=1, then release.
//     -> an=1111, seg=1111111, dp=1, frame_tick=0 during reset.
//     -> First lit slot: an=1110, seg=0000001.
//  2. load with digits_in=16'h12AF, dp_in=4'b0010.
//     -> After the next wrap, slots show F (0111000, dp=1), A (0001000, dp=0), 2, 1.
//     -> an sequence 1110, 1101, 1011, 0111; pending is 1 until the wrap.
//  3. Load 16'h1111, then load 16'h2222 within the same frame.
//     -> At the wrap only 2222 is displayed (0010010 on all digits); 1111 never appears.
//  4. load asserted on the exact wrap cycle.
//     -> Data is displayed from digit 0 of the new frame; pending stays 0.
//  5. LZ_SUPPRESS=1, digits_in=16'h0050, blank_in=0.
//     -> Digits 3 and 2 dark (seg=1111111, an still scans); digit 1=5 (0100100); digit 0=0 lit.
//     -> digits_in=16'h0000 -> only digit 0 lit.
//  6. Assert rst mid-slot with index=2.
//     -> Outputs dark immediately (async); pending=0.
//     -> After release, scan restarts at an=1110 and displays 0.

Source files
------------

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed hex display driver for a common-anode, active-low display.
// Digit data is double-buffered: a load strobe fills a shadow copy and the
// shadow is promoted to the active copy only when the scan wraps to digit 0.
// This keeps a frame from ever mixing old and new digits.
// Every digit slot opens with a few guard cycles with all anodes off, so
// the previous digit's segments cannot ghost onto the next anode.

module seven_seg_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 8,
  parameter int LZ_SUPPRESS  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick,
  output logic                    pending
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] GUARD_LIM  = PW'(GUARD_CYCLES);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Scan position state
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          lastCycle;
  logic          wrap;

  // Active buffer (what is being displayed) and shadow buffer (latest load)
  logic [4*NUM_DIGITS-1:0] actDigits_q, actDigits_d;
  logic [NUM_DIGITS-1:0]   actBlank_q, actBlank_d;
  logic [NUM_DIGITS-1:0]   actDp_q, actDp_d;
  logic [4*NUM_DIGITS-1:0] shDigits_q, shDigits_d;
  logic [NUM_DIGITS-1:0]   shBlank_q, shBlank_d;
  logic [NUM_DIGITS-1:0]   shDp_q, shDp_d;
  logic                    pending_q, pending_d;

  // Registered display outputs
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frameTick_q;

  // Per-digit decode helpers
  logic [NUM_DIGITS-1:0] zeroOrBlank;
  logic [NUM_DIGITS-1:0] lzDark;
  logic [3:0]            curNib;
  logic                  curBlank;
  logic                  curLz;
  logic                  curDp;
  logic                  inGuard;
  logic                  upperRun;

  // Hex nibble to active-low segment pattern, bit 6 = a .. bit 0 = g
  function automatic logic [6:0] hexToSeg(input logic [3:0] v);
    logic [6:0] s;
    s = 7'b1111111;
    case (v)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      4'hF: s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Prescaler and digit index advance; a wrap is the last cycle of the last digit
  always_comb begin
    lastCycle = (presc_q == PRESC_LAST);
    wrap      = lastCycle && (idx_q == IDX_LAST);
    presc_d   = lastCycle ? '0 : presc_q + PW'(1);
    idx_d     = idx_q;
    if (lastCycle) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Double-buffer control: a load on the wrap cycle goes straight to active,
  // otherwise loads park in shadow until the next wrap promotes them
  always_comb begin
    actDigits_d = actDigits_q;
    actBlank_d  = actBlank_q;
    actDp_d     = actDp_q;
    shDigits_d  = shDigits_q;
    shBlank_d   = shBlank_q;
    shDp_d      = shDp_q;
    pending_d   = pending_q;
    if (load && wrap) begin
      actDigits_d = digits_in;
      actBlank_d  = blank_in;
      actDp_d     = dp_in;
      shDigits_d  = digits_in;
      shBlank_d   = blank_in;
      shDp_d      = dp_in;
      pending_d   = 1'b0;
    end else if (load) begin
      shDigits_d = digits_in;
      shBlank_d  = blank_in;
      shDp_d     = dp_in;
      pending_d  = 1'b1;
    end else if (wrap && pending_q) begin
      actDigits_d = shDigits_q;
      actBlank_d  = shBlank_q;
      actDp_d     = shDp_q;
      pending_d   = 1'b0;
    end
  end

  // Leading-zero map: a position is a leading zero when it and every higher
  // digit is zero or forced blank; digit 0 always stays lit
  always_comb begin
    zeroOrBlank = '0;
    lzDark      = '0;
    upperRun    = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zeroOrBlank[k] = (actDigits_q[4*k +: 4] == 4'h0) || actBlank_q[k];
    end
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      upperRun  = upperRun && zeroOrBlank[k];
      lzDark[k] = (LZ_SUPPRESS != 0) && (k > 0) && upperRun;
    end
  end

  // Select the digit under the scan and form the next anode/segment/dp values
  always_comb begin
    curNib   = 4'h0;
    curBlank = 1'b0;
    curLz    = 1'b0;
    curDp    = 1'b0;
    an_d     = '1;
    seg_d    = 7'b1111111;
    dp_d     = 1'b1;
    inGuard  = (presc_q < GUARD_LIM);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        curNib   = actDigits_q[4*k +: 4];
        curBlank = actBlank_q[k];
        curLz    = lzDark[k];
        curDp    = actDp_q[k];
      end
    end
    if (!inGuard) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IW'(k)) begin
          an_d[k] = 1'b0;
        end
      end
      if (!(curBlank || curLz)) begin
        seg_d = hexToSeg(curNib);
        dp_d  = ~curDp;
      end
    end
  end

  // Scan position registers and wrap pulse (pulse lands with index back at 0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q     <= '0;
      idx_q       <= '0;
      frameTick_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      frameTick_q <= wrap;
    end
  end

  // Shadow and active digit buffers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      actDigits_q <= '0;
      actBlank_q  <= '0;
      actDp_q     <= '0;
      shDigits_q  <= '0;
      shBlank_q   <= '0;
      shDp_q      <= '0;
      pending_q   <= 1'b0;
    end else begin
      actDigits_q <= actDigits_d;
      actBlank_q  <= actBlank_d;
      actDp_q     <= actDp_d;
      shDigits_q  <= shDigits_d;
      shBlank_q   <= shBlank_d;
      shDp_q      <= shDp_d;
      pending_q   <= pending_d;
    end
  end

  // Output registers so the pins are glitch-free; they trail scan state by a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frameTick_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_seven_seg_scan_mux.sv
// Directed bench for seven_seg_scan_mux with a 4-cycle slot and 1 guard cycle.
// Two instances share the stimulus: dutA without and dutB with leading-zero
// suppression. The cycle counter cyc counts rising edges since reset release;
// outputs seen after edge n reflect scan state n-1, i.e. prescaler (n-1)%4 and
// digit ((n-1)/4)%4, so lit slots are at n = 4*slot + 2 and wraps land on n%16==0.

module tb_seven_seg_scan_mux;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digitsIn;
  logic [3:0]  blankIn;
  logic [3:0]  dpIn;

  logic [6:0] segA, segB;
  logic       dpA, dpB;
  logic [3:0] anA, anB;
  logic       frameTickA, frameTickB;
  logic       pendingA, pendingB;

  int cyc;
  int nCompared;
  int nMismatched;

  seven_seg_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1), .LZ_SUPPRESS(0)
  ) dutA (
    .clk(clk), .rst(rst), .load(load), .digits_in(digitsIn), .blank_in(blankIn),
    .dp_in(dpIn), .seg(segA), .dp(dpA), .an(anA), .frame_tick(frameTickA),
    .pending(pendingA)
  );

  seven_seg_scan_mux #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .GUARD_CYCLES(1), .LZ_SUPPRESS(1)
  ) dutB (
    .clk(clk), .rst(rst), .load(load), .digits_in(digitsIn), .blank_in(blankIn),
    .dp_in(dpIn), .seg(segB), .dp(dpB), .an(anB), .frame_tick(frameTickB),
    .pending(pendingB)
  );

  // 10 time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to rising edge number target, sampling point 1 unit after the edge
  task automatic advanceTo(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Reset values, then the first guard and first lit slot after release
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nCompared++; if (anA !== 4'b1111) begin nMismatched++; $display("[TB] FAIL reset.an got %b want 1111", anA); end
    nCompared++; if (segA !== 7'b1111111) begin nMismatched++; $display("[TB] FAIL reset.seg got %b want 1111111", segA); end
    nCompared++; if (dpA !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset.dp got %b want 1", dpA); end
    nCompared++; if (frameTickA !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset.frame_tick got %b want 0", frameTickA); end
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset.pending got %b want 0", pendingA); end
    nCompared++; if (anB !== 4'b1111) begin nMismatched++; $display("[TB] FAIL reset.anB got %b want 1111", anB); end
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    advanceTo(1);
    nCompared++; if (anA !== 4'b1111) begin nMismatched++; $display("[TB] FAIL first_guard.an got %b want 1111", anA); end
    advanceTo(2);
    nCompared++; if (anA !== 4'b1110) begin nMismatched++; $display("[TB] FAIL first_lit.an got %b want 1110", anA); end
    nCompared++; if (segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL first_lit.seg got %b want 0000001", segA); end
    nCompared++; if (dpA !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_lit.dp got %b want 1", dpA); end
    nCompared++; if (frameTickA !== 1'b0) begin nMismatched++; $display("[TB] FAIL first_lit.frame_tick got %b want 0", frameTickA); end
  endtask

  // Load 12AF with dp on digit 1, applied only at the next wrap, then scanned
  task automatic test_load_scan;
    logic [3:0] anExp [4];
    logic [6:0] segExp [4];
    logic       dpExp [4];
    anExp  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    segExp = '{7'b0111000, 7'b0001000, 7'b0010010, 7'b1001111};
    dpExp  = '{1'b1, 1'b0, 1'b1, 1'b1};
    advanceTo(2);
    digitsIn = 16'h12AF; blankIn = 4'b0000; dpIn = 4'b0010; load = 1'b1;
    advanceTo(3);
    load = 1'b0;
    nCompared++; if (pendingA !== 1'b1) begin nMismatched++; $display("[TB] FAIL load.pending_set got %b want 1", pendingA); end
    advanceTo(10);
    nCompared++; if (segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL load.old_data_held got %b want 0000001", segA); end
    advanceTo(15);
    nCompared++; if (pendingA !== 1'b1) begin nMismatched++; $display("[TB] FAIL load.pending_before_wrap got %b want 1", pendingA); end
    nCompared++; if (frameTickA !== 1'b0) begin nMismatched++; $display("[TB] FAIL load.tick_before_wrap got %b want 0", frameTickA); end
    advanceTo(16);
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL load.pending_cleared got %b want 0", pendingA); end
    nCompared++; if (frameTickA !== 1'b1) begin nMismatched++; $display("[TB] FAIL load.frame_tick got %b want 1", frameTickA); end
    for (int k = 0; k < 4; k++) begin
      advanceTo(17 + 4*k);
      nCompared++; if (anA !== 4'b1111 || segA !== 7'b1111111) begin nMismatched++; $display("[TB] FAIL scan.guard%0d got an=%b seg=%b want an=1111 seg=1111111", k, anA, segA); end
      if (k == 0) begin
        nCompared++; if (frameTickA !== 1'b0) begin nMismatched++; $display("[TB] FAIL scan.tick_one_cycle got %b want 0", frameTickA); end
      end
      advanceTo(18 + 4*k);
      nCompared++; if (anA !== anExp[k]) begin nMismatched++; $display("[TB] FAIL scan.an%0d got %b want %b", k, anA, anExp[k]); end
      nCompared++; if (segA !== segExp[k]) begin nMismatched++; $display("[TB] FAIL scan.seg%0d got %b want %b", k, segA, segExp[k]); end
      nCompared++; if (dpA !== dpExp[k]) begin nMismatched++; $display("[TB] FAIL scan.dp%0d got %b want %b", k, dpA, dpExp[k]); end
    end
  endtask

  // Two loads in one frame: only the second reaches the display
  task automatic test_back_to_back;
    logic [3:0] anExp [4];
    anExp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    advanceTo(33);
    digitsIn = 16'h1111; blankIn = 4'b0000; dpIn = 4'b0000; load = 1'b1;
    advanceTo(34);
    load = 1'b0;
    advanceTo(36);
    digitsIn = 16'h2222; load = 1'b1;
    advanceTo(37);
    load = 1'b0;
    advanceTo(40);
    nCompared++; if (pendingA !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b.pending got %b want 1", pendingA); end
    advanceTo(48);
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b.pending_cleared got %b want 0", pendingA); end
    for (int k = 0; k < 4; k++) begin
      advanceTo(50 + 4*k);
      nCompared++; if (anA !== anExp[k]) begin nMismatched++; $display("[TB] FAIL b2b.an%0d got %b want %b", k, anA, anExp[k]); end
      nCompared++; if (segA !== 7'b0010010) begin nMismatched++; $display("[TB] FAIL b2b.seg%0d got %b want 0010010", k, segA); end
    end
  endtask

  // Load landing on the wrap cycle goes straight to the new frame
  task automatic test_load_on_wrap;
    logic [6:0] segExp [4];
    segExp = '{7'b0100000, 7'b0100100, 7'b1001100, 7'b0000110};
    advanceTo(63);
    digitsIn = 16'h3456; blankIn = 4'b0000; dpIn = 4'b0000; load = 1'b1;
    advanceTo(64);
    load = 1'b0;
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrapload.pending got %b want 0", pendingA); end
    nCompared++; if (frameTickA !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrapload.frame_tick got %b want 1", frameTickA); end
    advanceTo(65);
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL wrapload.pending_after got %b want 0", pendingA); end
    for (int k = 0; k < 4; k++) begin
      advanceTo(66 + 4*k);
      nCompared++; if (segA !== segExp[k]) begin nMismatched++; $display("[TB] FAIL wrapload.seg%0d got %b want %b", k, segA, segExp[k]); end
      nCompared++; if (dpA !== 1'b1) begin nMismatched++; $display("[TB] FAIL wrapload.dp%0d got %b want 1", k, dpA); end
    end
  endtask

  // Leading-zero suppression on dutB, compared against dutA without it
  task automatic test_lz_suppress;
    logic [3:0] anExp [4];
    logic [6:0] segB1 [4];
    logic [6:0] segB3 [4];
    logic [6:0] segA3 [4];
    logic       dpA3 [4];
    anExp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    segB1 = '{7'b0000001, 7'b0100100, 7'b1111111, 7'b1111111};
    segB3 = '{7'b0000001, 7'b0000110, 7'b1111111, 7'b1111111};
    segA3 = '{7'b0000001, 7'b0000110, 7'b0000001, 7'b1111111};
    dpA3  = '{1'b1, 1'b1, 1'b0, 1'b1};
    advanceTo(80);
    digitsIn = 16'h0050; blankIn = 4'b0000; dpIn = 4'b0000; load = 1'b1;
    advanceTo(81);
    load = 1'b0;
    nCompared++; if (pendingB !== 1'b1) begin nMismatched++; $display("[TB] FAIL lz.pendingB got %b want 1", pendingB); end
    advanceTo(96);
    nCompared++; if (frameTickB !== 1'b1) begin nMismatched++; $display("[TB] FAIL lz.frame_tickB got %b want 1", frameTickB); end
    for (int k = 0; k < 4; k++) begin
      advanceTo(98 + 4*k);
      nCompared++; if (anB !== anExp[k]) begin nMismatched++; $display("[TB] FAIL lz0050.an%0d got %b want %b", k, anB, anExp[k]); end
      nCompared++; if (segB !== segB1[k]) begin nMismatched++; $display("[TB] FAIL lz0050.seg%0d got %b want %b", k, segB, segB1[k]); end
      if (k == 2) begin
        nCompared++; if (segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL nolz0050.seg2 got %b want 0000001", segA); end
      end
    end
    advanceTo(112);
    digitsIn = 16'h0000; load = 1'b1;
    advanceTo(113);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      advanceTo(130 + 4*k);
      nCompared++; if (anB !== anExp[k]) begin nMismatched++; $display("[TB] FAIL lz0000.an%0d got %b want %b", k, anB, anExp[k]); end
      nCompared++; if (segB !== ((k == 0) ? 7'b0000001 : 7'b1111111)) begin nMismatched++; $display("[TB] FAIL lz0000.seg%0d got %b want %b", k, segB, ((k == 0) ? 7'b0000001 : 7'b1111111)); end
    end
    advanceTo(144);
    digitsIn = 16'h5030; blankIn = 4'b1000; dpIn = 4'b0100; load = 1'b1;
    advanceTo(145);
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      advanceTo(162 + 4*k);
      nCompared++; if (segB !== segB3[k]) begin nMismatched++; $display("[TB] FAIL lzblank.segB%0d got %b want %b", k, segB, segB3[k]); end
      nCompared++; if (dpB !== 1'b1) begin nMismatched++; $display("[TB] FAIL lzblank.dpB%0d got %b want 1", k, dpB); end
      nCompared++; if (segA !== segA3[k]) begin nMismatched++; $display("[TB] FAIL blank.segA%0d got %b want %b", k, segA, segA3[k]); end
      nCompared++; if (dpA !== dpA3[k]) begin nMismatched++; $display("[TB] FAIL blank.dpA%0d got %b want %b", k, dpA, dpA3[k]); end
      nCompared++; if (anA !== anExp[k]) begin nMismatched++; $display("[TB] FAIL blank.anA%0d got %b want %b", k, anA, anExp[k]); end
    end
  endtask

  // Asynchronous reset in the middle of digit 2 with a load still pending
  task automatic test_reset_mid_slot;
    advanceTo(184);
    digitsIn = 16'h9999; blankIn = 4'b0000; dpIn = 4'b0000; load = 1'b1;
    advanceTo(185);
    load = 1'b0;
    advanceTo(186);
    nCompared++; if (anA !== 4'b1011) begin nMismatched++; $display("[TB] FAIL midrst.an_before got %b want 1011", anA); end
    nCompared++; if (segA !== 7'b0000001 || dpA !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst.seg_before got seg=%b dp=%b want seg=0000001 dp=0", segA, dpA); end
    nCompared++; if (pendingA !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst.pending_before got %b want 1", pendingA); end
    #2;
    rst = 1'b1;
    #1;
    nCompared++; if (anA !== 4'b1111) begin nMismatched++; $display("[TB] FAIL midrst.an_async got %b want 1111", anA); end
    nCompared++; if (segA !== 7'b1111111) begin nMismatched++; $display("[TB] FAIL midrst.seg_async got %b want 1111111", segA); end
    nCompared++; if (dpA !== 1'b1) begin nMismatched++; $display("[TB] FAIL midrst.dp_async got %b want 1", dpA); end
    nCompared++; if (pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst.pending_async got %b want 0", pendingA); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    advanceTo(1);
    nCompared++; if (anA !== 4'b1111) begin nMismatched++; $display("[TB] FAIL restart.guard got %b want 1111", anA); end
    advanceTo(2);
    nCompared++; if (anA !== 4'b1110) begin nMismatched++; $display("[TB] FAIL restart.an got %b want 1110", anA); end
    nCompared++; if (segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL restart.seg got %b want 0000001", segA); end
    advanceTo(6);
    nCompared++; if (anA !== 4'b1101 || segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL restart.digit1 got an=%b seg=%b want an=1101 seg=0000001", anA, segA); end
    advanceTo(16);
    nCompared++; if (frameTickA !== 1'b1 || pendingA !== 1'b0) begin nMismatched++; $display("[TB] FAIL restart.wrap got tick=%b pending=%b want tick=1 pending=0", frameTickA, pendingA); end
    advanceTo(18);
    nCompared++; if (segA !== 7'b0000001) begin nMismatched++; $display("[TB] FAIL restart.shadow_cleared got %b want 0000001", segA); end
  endtask

  // Run every scenario in order and report
  initial begin
    nCompared   = 0;
    nMismatched = 0;
    cyc         = 0;
    rst         = 1'b1;
    load        = 1'b0;
    digitsIn    = 16'h0000;
    blankIn     = 4'b0000;
    dpIn        = 4'b0000;
    $display("[TB] starting seven_seg_scan_mux bench");
    test_reset;
    test_load_scan;
    test_back_to_back;
    test_load_on_wrap;
    test_lz_suppress;
    test_reset_mid_slot;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
